hwag_tooth_sync: RTL and testbench

- Downstream of the VR capture, period-capture and gap-search stage.
- Consumes the filtered tooth-edge strobe, the gap flag and the period-counter overflow.
- Numbers the real teeth, verifies that the gap recurs at the expected position and asserts crank sync.
- Its tooth number and revolution strobe feed the later angle-generation stages.

---
 rtl/hwag_tooth_sync.sv | 168 ++++++++++++++++
 tb/tb_hwag_tooth_sync.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_tooth_sync.sv
// hwag_tooth_sync: numbers the real teeth of a missing-tooth crank wheel,
// confirms that the gap comes back at the expected tooth and flags crank sync.
// The edge strobe is delayed by one clock (edge_d) so that the gap flag, which
// comes from capture registers loaded on the edge, is stable when sampled.
// An edge in cycle N therefore changes the registered outputs in cycle N+2.
// The edge strobe port is called tooth_edge because "edge" is a reserved word.
// Optional feature: define HWAG_SYNC_ERR_CNT_EN to add a saturating error
// counter (err_cnt) and its clear input (err_clr).

module hwag_tooth_sync #(
    parameter int TCNT_W        = 6,
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int VERIFY_REVS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tooth_edge,
    input  logic              gap,
    input  logic              stop,
`ifdef HWAG_SYNC_ERR_CNT_EN
    input  logic              err_clr,
    output logic [7:0]        err_cnt,
`endif
    output logic [TCNT_W-1:0] tcnt,
    output logic              sync,
    output logic              rev,
    output logic              err,
    output logic [1:0]        state
);

    // Number of the last real tooth before the gap.
    localparam logic [TCNT_W-1:0] LAST = TCNT_W'(TEETH_TOTAL - TEETH_MISSING - 1);
    localparam logic [3:0]        VREVS = 4'(VERIFY_REVS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_SYNC   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
    logic [3:0]        vcnt_reg, vcnt_next;
    logic              sync_reg, sync_next;
    logic              rev_reg, rev_next;
    logic              err_reg, err_next;
    logic              edge_d;
    logic [3:0]        vcnt_inc;

    assign vcnt_inc = vcnt_reg + 4'd1;

    // Delay the tooth strobe so the gap flag is evaluated after the capture update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_d <= 1'b0;
        end else begin
            edge_d <= tooth_edge;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            tcnt_reg  <= '0;
            vcnt_reg  <= '0;
            sync_reg  <= 1'b0;
            rev_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tcnt_reg  <= tcnt_next;
            vcnt_reg  <= vcnt_next;
            sync_reg  <= sync_next;
            rev_reg   <= rev_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: stop overrides everything, otherwise act once per delayed edge.
    always_comb begin
        state_next = state_reg;
        tcnt_next  = tcnt_reg;
        vcnt_next  = vcnt_reg;
        sync_next  = sync_reg;
        rev_next   = 1'b0;
        err_next   = 1'b0;

        if (stop) begin
            // Engine stopped: drop everything and wait in IDLE.
            state_next = ST_IDLE;
            tcnt_next  = '0;
            vcnt_next  = '0;
            sync_next  = 1'b0;
        end else if (edge_d) begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_SEARCH;
                    tcnt_next  = '0;
                end
                ST_SEARCH: begin
                    if (gap) begin
                        state_next = ST_VERIFY;
                        tcnt_next  = '0;
                        vcnt_next  = '0;
                    end
                end
                default: begin
                    if (gap && (tcnt_reg == LAST)) begin
                        // Gap exactly where expected.
                        tcnt_next = '0;
                        if (state_reg == ST_VERIFY) begin
                            vcnt_next = vcnt_inc;
                            if (vcnt_inc == VREVS) begin
                                state_next = ST_SYNC;
                                sync_next  = 1'b1;
                            end
                        end else begin
                            rev_next = 1'b1;
                        end
                    end else if (gap) begin
                        // Early gap: take it as the new reference and re-verify.
                        err_next   = 1'b1;
                        tcnt_next  = '0;
                        vcnt_next  = '0;
                        sync_next  = 1'b0;
                        state_next = ST_VERIFY;
                    end else if (tcnt_reg == LAST) begin
                        // Gap missing where expected: position is lost.
                        err_next   = 1'b1;
                        tcnt_next  = '0;
                        vcnt_next  = '0;
                        sync_next  = 1'b0;
                        state_next = ST_SEARCH;
                    end else begin
                        tcnt_next = tcnt_reg + TCNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef HWAG_SYNC_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    // Saturating count of err pulses; a clear coinciding with err leaves a count of one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_reg <= 8'd0;
        end else if (err_clr) begin
            err_cnt_reg <= err_reg ? 8'd1 : 8'd0;
        end else if (err_reg && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign tcnt  = tcnt_reg;
    assign sync  = sync_reg;
    assign rev   = rev_reg;
    assign err   = err_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Directed bench for hwag_tooth_sync: a default instance (VERIFY_REVS=1) and a
// VERIFY_REVS=3 instance share the same stimulus; each scenario task checks
// hand-computed expectations inline.

module tb_hwag_tooth_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tooth_edge = 1'b0;
    logic       gap = 1'b0;
    logic       stop = 1'b0;
    logic [5:0] tcnt, tcnt3;
    logic       sync, sync3, rev, rev3, err, err3;
    logic [1:0] state, state3;
`ifdef HWAG_SYNC_ERR_CNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt, err_cnt3;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    hwag_tooth_sync #(.TCNT_W(6), .TEETH_TOTAL(60), .TEETH_MISSING(2), .VERIFY_REVS(1)) dut (
        .clk(clk), .rst(rst), .tooth_edge(tooth_edge), .gap(gap), .stop(stop),
`ifdef HWAG_SYNC_ERR_CNT_EN
        .err_clr(err_clr), .err_cnt(err_cnt),
`endif
        .tcnt(tcnt), .sync(sync), .rev(rev), .err(err), .state(state)
    );

    hwag_tooth_sync #(.TCNT_W(6), .TEETH_TOTAL(60), .TEETH_MISSING(2), .VERIFY_REVS(3)) dut3 (
        .clk(clk), .rst(rst), .tooth_edge(tooth_edge), .gap(gap), .stop(stop),
`ifdef HWAG_SYNC_ERR_CNT_EN
        .err_clr(err_clr), .err_cnt(err_cnt3),
`endif
        .tcnt(tcnt3), .sync(sync3), .rev(rev3), .err(err3), .state(state3)
    );

    // One tooth: edge pulse for a clock, gap held through the evaluation
    // cycle; returns at the negedge where the resulting outputs are visible.
    task automatic tooth(input logic g);
        tooth_edge = 1'b1;
        gap = g;
        @(negedge clk);
        tooth_edge = 1'b0;
        @(negedge clk);
        $display("tooth gap=%0b -> state=%0d tcnt=%0d sync=%0b rev=%0b err=%0b",
                 g, state, tcnt, sync, rev, err);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
        n_total++;
        if (tcnt !== 6'd0) $display("FAIL reset_tcnt got=%0d exp=0", tcnt); else n_pass++;
        n_total++;
        if ({sync, rev, err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {sync, rev, err}); else n_pass++;
        n_total++;
        if (state3 !== 2'd0) $display("FAIL reset_state3 got=%0d exp=0", state3); else n_pass++;
        n_total++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_acquire;
        int errs;
        int tbad;
        errs = 0;
        tbad = 0;
        tooth(1'b0);
        if (state !== 2'd1) $display("FAIL acq_search state got=%0d exp=1", state); else n_pass++;
        n_total++;
        tooth(1'b0);
        if (state !== 2'd1) $display("FAIL acq_hold state got=%0d exp=1", state); else n_pass++;
        n_total++;
        tooth(1'b1);
        if (state !== 2'd2 || tcnt !== 6'd0) $display("FAIL acq_verify state/tcnt got=%0d/%0d exp=2/0", state, tcnt); else n_pass++;
        n_total++;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 57; i++) begin
                tooth(1'b0);
                if (tcnt !== 6'(i)) tbad++;
                if (err) errs++;
            end
            tooth(1'b1);
            if (err) errs++;
            if (r == 0) begin
                if (state !== 2'd3 || sync !== 1'b1 || rev !== 1'b0)
                    $display("FAIL acq_sync state/sync/rev got=%0d/%b/%b exp=3/1/0", state, sync, rev);
                else n_pass++;
                n_total++;
            end else begin
                if (rev !== 1'b1 || tcnt !== 6'd0) $display("FAIL acq_rev rev/tcnt got=%b/%0d exp=1/0", rev, tcnt); else n_pass++;
                n_total++;
            end
        end
        if (tbad !== 0) $display("FAIL acq_tcnt_seq bad_teeth got=%0d exp=0", tbad); else n_pass++;
        n_total++;
        if (errs !== 0) $display("FAIL acq_no_err err_pulses got=%0d exp=0", errs); else n_pass++;
        n_total++;
        @(negedge clk);
        if (rev !== 1'b0) $display("FAIL acq_rev_width rev got=%b exp=0", rev); else n_pass++;
        n_total++;
    endtask

    task automatic test_early_gap;
        repeat (40) tooth(1'b0);
        if (tcnt !== 6'd40) $display("FAIL early_pre tcnt got=%0d exp=40", tcnt); else n_pass++;
        n_total++;
        tooth(1'b1);
        if ({err, rev, sync} !== 3'b100 || state !== 2'd2 || tcnt !== 6'd0)
            $display("FAIL early_gap err/rev/sync/state/tcnt got=%b%b%b/%0d/%0d exp=100/2/0", err, rev, sync, state, tcnt);
        else n_pass++;
        n_total++;
        repeat (57) tooth(1'b0);
        tooth(1'b1);
        if (state !== 2'd3 || sync !== 1'b1 || err !== 1'b0)
            $display("FAIL early_resync state/sync/err got=%0d/%b/%b exp=3/1/0", state, sync, err);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_missed_gap;
        repeat (57) tooth(1'b0);
        if (tcnt !== 6'd57) $display("FAIL missed_pre tcnt got=%0d exp=57", tcnt); else n_pass++;
        n_total++;
        tooth(1'b0);
        if ({err, rev, sync} !== 3'b100 || state !== 2'd1 || tcnt !== 6'd0)
            $display("FAIL missed_gap err/rev/sync/state/tcnt got=%b%b%b/%0d/%0d exp=100/1/0", err, rev, sync, state, tcnt);
        else n_pass++;
        n_total++;
        repeat (5) tooth(1'b0);
        if (state !== 2'd1 || tcnt !== 6'd0) $display("FAIL missed_frozen state/tcnt got=%0d/%0d exp=1/0", state, tcnt); else n_pass++;
        n_total++;
        tooth(1'b1);
        if (state !== 2'd2) $display("FAIL missed_reverify state got=%0d exp=2", state); else n_pass++;
        n_total++;
        repeat (57) tooth(1'b0);
        tooth(1'b1);
        if (state !== 2'd3) $display("FAIL missed_resync state got=%0d exp=3", state); else n_pass++;
        n_total++;
    endtask

    task automatic test_stop;
        repeat (20) tooth(1'b0);
        if (tcnt !== 6'd20) $display("FAIL stop_pre tcnt got=%0d exp=20", tcnt); else n_pass++;
        n_total++;
        stop = 1'b1;
        tooth_edge = 1'b1;
        gap = 1'b0;
        @(negedge clk);
        tooth_edge = 1'b0;
        $display("stop applied -> state=%0d tcnt=%0d sync=%0b", state, tcnt, sync);
        if (state !== 2'd0 || tcnt !== 6'd0 || {sync, rev, err} !== 3'b000)
            $display("FAIL stop_idle state/tcnt/flags got=%0d/%0d/%b exp=0/0/000", state, tcnt, {sync, rev, err});
        else n_pass++;
        n_total++;
        repeat (3) @(negedge clk);
        if (state !== 2'd0 || {rev, err} !== 2'b00) $display("FAIL stop_hold state/rev/err got=%0d/%b exp=0/00", state, {rev, err}); else n_pass++;
        n_total++;
        stop = 1'b0;
        @(negedge clk);
        tooth(1'b0);
        if (state !== 2'd1) $display("FAIL stop_restart state got=%0d exp=1", state); else n_pass++;
        n_total++;
    endtask

    task automatic test_async_reset;
        tooth(1'b1);
        repeat (57) tooth(1'b0);
        tooth(1'b1);
        repeat (10) tooth(1'b0);
        if (state !== 2'd3 || tcnt !== 6'd10) $display("FAIL areset_pre state/tcnt got=%0d/%0d exp=3/10", state, tcnt); else n_pass++;
        n_total++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        $display("async reset -> state=%0d tcnt=%0d sync=%0b", state, tcnt, sync);
        if (state !== 2'd0 || tcnt !== 6'd0 || sync !== 1'b0)
            $display("FAIL areset_clear state/tcnt/sync got=%0d/%0d/%b exp=0/0/0", state, tcnt, sync);
        else n_pass++;
        n_total++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_verify_revs3;
        tooth(1'b0);
        tooth(1'b1);
        if (state3 !== 2'd2) $display("FAIL vr3_verify state3 got=%0d exp=2", state3); else n_pass++;
        n_total++;
        for (int r = 1; r <= 3; r++) begin
            repeat (57) tooth(1'b0);
            tooth(1'b1);
            $display("vr3 good gap %0d -> state3=%0d sync3=%0b", r, state3, sync3);
            if (r < 3) begin
                if (state3 !== 2'd2 || sync3 !== 1'b0) $display("FAIL vr3_gap%0d state3/sync3 got=%0d/%b exp=2/0", r, state3, sync3); else n_pass++;
            end else begin
                if (state3 !== 2'd3 || sync3 !== 1'b1) $display("FAIL vr3_gap3 state3/sync3 got=%0d/%b exp=3/1", state3, sync3); else n_pass++;
            end
            n_total++;
        end
        if (sync !== 1'b1 || rev !== 1'b1) $display("FAIL vr1_ref sync/rev got=%b/%b exp=1/1", sync, rev); else n_pass++;
        n_total++;
    endtask

`ifdef HWAG_SYNC_ERR_CNT_EN
    task automatic test_err_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tooth(1'b0);
        tooth(1'b1);
        repeat (300) tooth(1'b1);
        @(negedge clk);
        if (err_cnt !== 8'd255) $display("FAIL errcnt_sat got=%0d exp=255", err_cnt); else n_pass++;
        n_total++;
        tooth(1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        $display("err_clr with err -> err_cnt=%0d", err_cnt);
        if (err_cnt !== 8'd1) $display("FAIL errcnt_clr_err got=%0d exp=1", err_cnt); else n_pass++;
        n_total++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_acquire();
        test_early_gap();
        test_missed_gap();
        test_stop();
        test_async_reset();
        test_verify_revs3();
`ifdef HWAG_SYNC_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
